// File: rtl/phase_strobe_generator.sv
// rtl/phase_strobe_generator.sv - free-running phase/period timebase with one-hot phase strobes and a wrap pulse
// The period step is staged through a load handshake and takes effect only at a period wrap.
module phase_strobe_generator #(
    parameter int CNT_W        = 10,
    parameter int N_PHASES     = 4,
    parameter int DEFAULT_STEP = 250
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [CNT_W-1:0]    i_step,
    input  logic                i_load,
    output logic                o_load_pend,
    output logic                o_load_err,
    output logic [CNT_W-1:0]    o_count,
    output logic [N_PHASES-1:0] o_strobe,
    output logic                o_wrap
);

    // One spare bit beyond CNT_W+clog2(N_PHASES) keeps the N_PHASES=1 case sliceable.
    localparam int               MW       = CNT_W + $clog2(N_PHASES) + 1;
    localparam logic [CNT_W-1:0] DEF_STEP = CNT_W'(DEFAULT_STEP);
    localparam logic [CNT_W-1:0] NPH      = CNT_W'(N_PHASES);

    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    step_q, step_d;
    logic [CNT_W-1:0]    pend_val_q, pend_val_d;
    logic                pend_q, pend_d;
    logic                err_q, err_d;
    logic                wrap_q, wrap_d;
    logic [N_PHASES-1:0] strobe_q, strobe_d;

    logic [CNT_W-1:0]    period_cur;
    logic [MW-1:0]       req_prod;
    logic                load_ok;
    logic                at_wrap;

    assign period_cur = step_q * NPH;
    assign req_prod   = MW'(i_step) * MW'(N_PHASES);
    assign load_ok    = (i_step != '0) && (req_prod < (MW'(1) << CNT_W));
    assign at_wrap    = i_en && (count_q == period_cur);

    always_comb begin
        count_d    = count_q;
        step_d     = step_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        strobe_d   = '0;
        wrap_d     = 1'b0;
        err_d      = 1'b0;

        if (i_en) begin
            if (at_wrap) begin
                count_d = CNT_W'(1);
                if (pend_q) begin
                    step_d = pend_val_q;
                    pend_d = 1'b0;
                end
            end else begin
                count_d = count_q + CNT_W'(1);
            end

            // Thresholds use the step that governs the period count_d belongs to.
            for (int k = 0; k < N_PHASES; k++) begin
                strobe_d[k] = (count_d == (step_d * CNT_W'(k + 1)));
            end
            wrap_d = (count_d == (step_d * NPH));
        end

        // Applied after the wrap so a coinciding load stages for the following period.
        if (i_load) begin
            if (load_ok) begin
                pend_d     = 1'b1;
                pend_val_d = i_step;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q    <= '0;
            step_q     <= DEF_STEP;
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
            strobe_q   <= '0;
        end else begin
            count_q    <= count_d;
            step_q     <= step_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
            strobe_q   <= strobe_d;
        end
    end

    assign o_count     = count_q;
    assign o_strobe    = strobe_q;
    assign o_wrap      = wrap_q;
    assign o_load_pend = pend_q;
    assign o_load_err  = err_q;

endmodule

// File: tb/tb_phase_strobe_generator.sv
// tb/tb_phase_strobe_generator.sv - scoreboard bench for phase_strobe_generator against an arithmetic reference model
module tb_phase_strobe_generator;

    localparam int CW = 10;
    localparam int NP = 4;
    localparam int DS = 250;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_en;
    logic          i_load;
    logic [CW-1:0] i_step;
    logic          o_load_pend;
    logic          o_load_err;
    logic [CW-1:0] o_count;
    logic [NP-1:0] o_strobe;
    logic          o_wrap;

    phase_strobe_generator #(.CNT_W(CW), .N_PHASES(NP), .DEFAULT_STEP(DS)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_step      (i_step),
        .i_load      (i_load),
        .o_load_pend (o_load_pend),
        .o_load_err  (o_load_err),
        .o_count     (o_count),
        .o_strobe    (o_strobe),
        .o_wrap      (o_wrap)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int cnt;
        int strobe;
        int wrap;
        int err;
        int pend;
    } exp_t;

    exp_t sb[$];
    int   m_cnt, m_step, m_pend, m_pv;
    int   total = 0;
    int   bad   = 0;

    // Reference: strobe k fires when the new count is the (k+1)-th multiple of step.
    always @(posedge i_clk) begin : model
        exp_t e;
        int   ns;
        e.err = 0; e.strobe = 0; e.wrap = 0;
        if (i_rst) begin
            m_cnt = 0; m_step = DS; m_pend = 0; m_pv = 0;
        end else begin
            if (i_en) begin
                if (m_cnt == m_step * NP) begin
                    m_cnt = 1;
                    if (m_pend != 0) begin
                        m_step = m_pv;
                        m_pend = 0;
                    end
                end else begin
                    m_cnt++;
                end
                if (m_cnt % m_step == 0) e.strobe = 1 << (m_cnt / m_step - 1);
                e.wrap = (m_cnt == m_step * NP) ? 1 : 0;
            end
            if (i_load) begin
                ns = int'(i_step);
                if (ns == 0 || ns * NP >= (1 << CW)) e.err = 1;
                else begin
                    m_pend = 1;
                    m_pv   = ns;
                end
            end
        end
        e.cnt  = m_cnt;
        e.pend = m_pend;
        sb.push_back(e);
    end

    task automatic chk(string n, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("count",    int'(o_count),     e.cnt);
                chk("strobe",   int'(o_strobe),    e.strobe);
                chk("wrap",     int'(o_wrap),      e.wrap);
                chk("load_err", int'(o_load_err),  e.err);
                chk("load_pend", int'(o_load_pend), e.pend);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic do_load(int s);
        i_load = 1'b1;
        i_step = CW'(s);
        tick(1);
        i_load = 1'b0;
    endtask

    task automatic wait_cnt(int v, string n);
        int k = 0;
        while (m_cnt != v && k < 5000) begin
            tick(1);
            k++;
        end
        total++;
        if (m_cnt != v) begin
            bad++;
            $display("FAIL wait_%s actual=%0d required=%0d (timeout)", n, m_cnt, v);
        end
    endtask

    initial begin : stim
        i_rst = 1'b1; i_en = 1'b0; i_load = 1'b0; i_step = '0;
        tick(3);
        i_rst = 1'b0;
        i_en  = 1'b1;
        tick(2100);

        wait_cnt(400, "load100");
        do_load(100);
        tick(1200);

        do_load(0);
        tick(5);
        do_load(256);
        tick(5);

        i_en = 1'b0;
        tick(20);
        i_en = 1'b1;
        tick(300);

        do_load(50);
        wait_cnt(m_step * NP, "wrap_load60");
        do_load(60);
        tick(700);

        i_rst = 1'b1;
        tick(2);
        i_rst = 1'b0;
        wait_cnt(250, "freeze250");
        i_en = 1'b0;
        tick(20);
        i_en = 1'b1;
        wait_cnt(590, "pend_then_rst");
        do_load(30);
        wait_cnt(600, "rst600");
        i_rst = 1'b1;
        tick(1);
        i_rst = 1'b0;
        tick(600);

        repeat (4000) begin
            i_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 3) begin
                i_load = 1'b1;
                case ($urandom_range(0, 3))
                    0:       i_step = '0;
                    1:       i_step = CW'($urandom_range(1, 8));
                    2:       i_step = CW'($urandom_range(250, 260));
                    default: i_step = CW'($urandom_range(1, 255));
                endcase
            end else begin
                i_load = 1'b0;
            end
            i_rst = ($urandom_range(0, 999) == 0);
            tick(1);
        end
        i_rst  = 1'b0;
        i_load = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
